// File: rtl/fft_pkg.sv
// fft_pkg: shared multiplier widths, latency, arbiter FSM states and round-robin pointer helper
package fft_pkg;
    localparam int MUL_A_W = 17;
    localparam int MUL_B_W = 8;
    localparam int MUL_LAT = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    function automatic logic [2:0] rr_next(input logic [2:0] g, input int unsigned n);
        return (g == 3'(n - 1)) ? 3'd0 : g + 3'd1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first unmasked valid requester at or after ptr, wrapping
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);
    logic [N_REQ-1:0] cand;

    assign cand = valid & ~mask;

    // Scan from farthest to nearest so the closest candidate to ptr wins
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[(int'(ptr) + k) % N_REQ]) begin
                gnt                               = '0;
                gnt[(int'(ptr) + k) % N_REQ]      = 1'b1;
                gnt_id                            = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one pipelined 17x8 multiplier among N_REQ requesters,
// with an enable/flush FSM and an ID tag pipe that routes each product back to its issuer
module mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 4,
    parameter int ID_W    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              flush,
    input  logic [N_REQ-1:0]                  cfg_mask,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [fft_pkg::MUL_A_W*N_REQ-1:0] req_a,
    input  logic [fft_pkg::MUL_B_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [fft_pkg::MUL_A_W-1:0]       mul_a,
    output logic [fft_pkg::MUL_B_W-1:0]       mul_b,
    input  logic [fft_pkg::MUL_A_W-1:0]       mul_p,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [fft_pkg::MUL_A_W-1:0]       rsp_data,
    output logic                              busy,
    output logic                              flush_done
);
    import fft_pkg::*;

    state_e                       state_q, state_d;
    logic [ID_W-1:0]              ptr_q, ptr_d, gnt_id;
    logic [N_REQ-1:0]             gnt;
    logic                         xfer;
    logic [MUL_A_W-1:0]           mul_a_q, mul_a_d;
    logic [MUL_B_W-1:0]           mul_b_q, mul_b_d;
    logic [MUL_LAT:0]             vld_q, vld_d;
    logic [MUL_LAT:0][ID_W-1:0]   id_q, id_d;
    logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [MUL_A_W-1:0]           rsp_data_q, rsp_data_d;
    logic                         flush_done_q, flush_done_d;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .mask   (cfg_mask),
        .valid  (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        req_ready    = (state_q == RUN && en && !flush) ? gnt : '0;
        xfer         = |req_ready;
        ptr_d        = xfer ? ID_W'(rr_next(3'(gnt_id), N_REQ)) : ptr_q;
        mul_a_d      = xfer ? req_a[MUL_A_W*gnt_id +: MUL_A_W] : '0;
        mul_b_d      = xfer ? req_b[MUL_B_W*gnt_id +: MUL_B_W] : '0;
        // Stage 0 lines up with mul_a; the last stage lines up with mul_p
        vld_d        = {vld_q[MUL_LAT-1:0], xfer};
        id_d         = {id_q[MUL_LAT-1:0], gnt_id};
        rsp_valid_d  = vld_q[MUL_LAT] ? (N_REQ'(1) << id_q[MUL_LAT]) : '0;
        rsp_data_d   = vld_q[MUL_LAT] ? mul_p : '0;
        busy         = |vld_q;
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d      = en ? RUN : IDLE;
                flush_done_d = flush;
            end
            RUN:     state_d = (flush || !en) ? DRAIN : RUN;
            DRAIN: begin
                state_d      = busy ? DRAIN : IDLE;
                flush_done_d = !busy;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            vld_q        <= '0;
            id_q         <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign flush_done = flush_done_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed scenarios plus a randomized run against a 4-cycle fractional multiplier model
module tb_mul_share_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  cfg_mask = '0;
    logic [3:0]  req_valid = '0;
    logic [67:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic [16:0] mul_a;
    logic [7:0]  mul_b;
    logic [16:0] mul_p;
    logic [3:0]  rsp_valid;
    logic [16:0] rsp_data;
    logic        busy;
    logic        flush_done;

    int passed = 0;
    int total = 0;

    // Hand-computed products of the fixed per-requester operands below
    logic [16:0] exp_p [4];

    mul_share_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .cfg_mask   (cfg_mask),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] fmul(input logic [16:0] a, input logic [7:0] b);
        logic signed [24:0] p;
        p = $signed(a) * $signed(b);
        return p[23:7];
    endfunction

    // multi16 model: operands presented in cycle c give mul_p in cycle c+4
    logic [16:0] mp0, mp1, mp2, mp3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp0 <= '0;
            mp1 <= '0;
            mp2 <= '0;
            mp3 <= '0;
        end else begin
            mp0 <= fmul(mul_a, mul_b);
            mp1 <= mp0;
            mp2 <= mp1;
            mp3 <= mp2;
        end
    end
    assign mul_p = mp3;

    task automatic apply_reset(input logic en_v);
        rst_n = 1'b0;
        en = 1'b0;
        flush = 1'b0;
        cfg_mask = '0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = en_v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        #1;
        total++; if (req_ready !== 4'h0) $display("FAIL reset_ready got=%b exp=0000", req_ready); else passed++;
        total++; if (rsp_valid !== 4'h0) $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); else passed++;
        total++; if (rsp_data !== 17'h0) $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); else passed++;
        total++; if ({mul_a, mul_b} !== 25'h0) $display("FAIL reset_mul_ops got=%h/%h exp=0/0", mul_a, mul_b); else passed++;
        total++; if ({busy, flush_done} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy, flush_done}); else passed++;
    endtask

    task automatic test_single;
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = (i == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (i == 0) begin
                total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else passed++;
            end
            if (i == 1) begin
                total++; if ({mul_a, mul_b} !== {17'h08000, 8'h40}) $display("FAIL single_mul_ops got=%h/%h exp=08000/40", mul_a, mul_b); else passed++;
                total++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passed++;
            end
            if (i == 5 || i == 7) begin
                total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_idle_%0d got=%b exp=0000", i, rsp_valid); else passed++;
            end
            if (i == 6) begin
                total++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); else passed++;
                total++; if (rsp_data !== 17'h04000) $display("FAIL single_rsp_data got=%h exp=04000", rsp_data); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] ev;
        apply_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = (i < 12) ? 4'hf : 4'h0;
            #1;
            if (i < 12) begin
                total++; if (req_ready !== (4'b0001 << (i % 4))) $display("FAIL b2b_ready_%0d got=%b exp=%b", i, req_ready, 4'b0001 << (i % 4)); else passed++;
            end
            ev = (i >= 6 && i < 18) ? (4'b0001 << ((i - 6) % 4)) : 4'b0000;
            total++; if (rsp_valid !== ev) $display("FAIL b2b_rsp_valid_%0d got=%b exp=%b", i, rsp_valid, ev); else passed++;
            if (i >= 6 && i < 18) begin
                total++; if (rsp_data !== exp_p[(i - 6) % 4]) $display("FAIL b2b_rsp_data_%0d got=%h exp=%h", i, rsp_data, exp_p[(i - 6) % 4]); else passed++;
            end
        end
    endtask

    task automatic test_mask;
        logic [3:0] eg;
        apply_reset(1'b1);
        cfg_mask = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid = 4'hf;
            if (i == 8) cfg_mask = 4'b0000;
            #1;
            eg = (i == 8) ? 4'b0001 : ((i % 2 == 0) ? 4'b0010 : 4'b1000);
            total++; if (req_ready !== eg) $display("FAIL mask_ready_%0d got=%b exp=%b", i, req_ready, eg); else passed++;
        end
    endtask

    task automatic test_flush;
        logic [3:0] eg, ev;
        apply_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = 4'hf;
            flush = (i == 3);
            en = (i < 4);
            #1;
            eg = (i < 3) ? (4'b0001 << i) : 4'b0000;
            ev = (i >= 6 && i <= 8) ? (4'b0001 << (i - 6)) : 4'b0000;
            total++; if (req_ready !== eg) $display("FAIL flush_ready_%0d got=%b exp=%b", i, req_ready, eg); else passed++;
            total++; if (rsp_valid !== ev) $display("FAIL flush_rsp_valid_%0d got=%b exp=%b", i, rsp_valid, ev); else passed++;
            if (i >= 6 && i <= 8) begin
                total++; if (rsp_data !== exp_p[i - 6]) $display("FAIL flush_rsp_data_%0d got=%h exp=%h", i, rsp_data, exp_p[i - 6]); else passed++;
            end
            total++; if (busy !== (i >= 1 && i <= 7)) $display("FAIL flush_busy_%0d got=%b exp=%b", i, busy, (i >= 1 && i <= 7)); else passed++;
            total++; if (flush_done !== (i == 9)) $display("FAIL flush_done_%0d got=%b exp=%b", i, flush_done, (i == 9)); else passed++;
        end
        flush = 1'b0;
    endtask

    task automatic test_idle_flush;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 4'hf;
            flush = (i == 1);
            #1;
            total++; if (req_ready !== 4'h0) $display("FAIL idle_ready_%0d got=%b exp=0000", i, req_ready); else passed++;
            total++; if (flush_done !== (i == 2)) $display("FAIL idle_flush_done_%0d got=%b exp=%b", i, flush_done, (i == 2)); else passed++;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midflight;
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 4'hf;
        end
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'h0;
        #1;
        total++; if ({rsp_valid, busy} !== 5'b0) $display("FAIL midrst_clear got=%b/%b exp=0000/0", rsp_valid, busy); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = (i == 9) ? 4'hf : 4'h0;
            #1;
            if (i < 9) begin
                total++; if (rsp_valid !== 4'h0) $display("FAIL midrst_rsp_%0d got=%b exp=0000", i, rsp_valid); else passed++;
            end else begin
                total++; if (req_ready !== 4'b0001) $display("FAIL midrst_first_grant got=%b exp=0001", req_ready); else passed++;
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  cand, eg, ev;
        logic        sv [8];
        int          sid [8];
        logic [16:0] sd [8];
        int          ptr_m, gid, idx;
        apply_reset(1'b1);
        ptr_m = 0;
        for (int s = 0; s < 8; s++) begin
            sv[s] = 1'b0;
            sid[s] = 0;
            sd[s] = '0;
        end
        for (int n = 0; n < 3008; n++) begin
            @(negedge clk);
            req_valid = (n < 3000) ? 4'($urandom()) : 4'h0;
            if (n % 37 == 0) cfg_mask = 4'($urandom());
            req_a = 68'({$urandom(), $urandom(), $urandom()});
            req_b = $urandom();
            #1;
            cand = req_valid & ~cfg_mask;
            eg = 4'h0;
            gid = 0;
            for (int k = 3; k >= 0; k--) begin
                idx = (ptr_m + k) % 4;
                if (cand[idx]) begin
                    eg = 4'b0001 << idx;
                    gid = idx;
                end
            end
            total++; if (req_ready !== eg) $display("FAIL rand_ready_%0d got=%b exp=%b", n, req_ready, eg); else passed++;
            ev = sv[n % 8] ? (4'b0001 << sid[n % 8]) : 4'b0000;
            total++; if (rsp_valid !== ev) $display("FAIL rand_rsp_valid_%0d got=%b exp=%b", n, rsp_valid, ev); else passed++;
            if (sv[n % 8]) begin
                total++; if (rsp_data !== sd[n % 8]) $display("FAIL rand_rsp_data_%0d got=%h exp=%h", n, rsp_data, sd[n % 8]); else passed++;
            end
            sv[n % 8] = 1'b0;
            if (eg != 4'h0) begin
                sv[(n + 6) % 8] = 1'b1;
                sid[(n + 6) % 8] = gid;
                sd[(n + 6) % 8] = fmul(req_a[17*gid +: 17], req_b[8*gid +: 8]);
                ptr_m = (gid + 1) % 4;
            end
        end
    endtask

    initial begin
        req_a = {17'h1F000, 17'h04000, 17'h10000, 17'h08000};
        req_b = {8'hC0, 8'h7F, 8'h40, 8'h40};
        exp_p[0] = 17'h04000;
        exp_p[1] = 17'h18000;
        exp_p[2] = 17'h03F80;
        exp_p[3] = 17'h00800;
        test_reset;
        test_single;
        test_back_to_back;
        test_mask;
        test_flush;
        test_idle_flush;
        test_reset_midflight;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
